alu_issue_ctrl: RTL and testbench

- Instruction-side counterpart of the ALU.
- Accepts one 32-bit ARM data-processing or MUL instruction per handshake and evaluates its condition field against the architectural NZVC register, which it owns.
- Drives the ALU 4-bit operation code and carry-in, then captures the ALU's nzvc result into the flag register.
- Sits between fetch/decode and the register-file/ALU datapath, and issues register-file write strobes.

---
 rtl/alu_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts ARM data-processing / MUL instructions, evaluates the
// condition against the owned NZVC register, drives ALU op/carry and register
// fields, and captures ALU flags on the final execute cycle.
module alu_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  alu_op,
  output logic        alu_carry,
  output logic        op_swap,
  input  logic [3:0]  alu_nzvc,
  output logic [3:0]  rn_addr,
  output logic [3:0]  rd_addr,
  output logic [3:0]  rm_addr,
  output logic [3:0]  rs_addr,
  output logic        op2_imm,
  output logic [11:0] op2_field,
  output logic        rd_we,
  input  logic        flags_load,
  input  logic [3:0]  flags_in,
  output logic [3:0]  flags,
  output logic        done,
  output logic        illegal
);

  localparam logic [3:0] OP_PLUS  = 4'd0,  OP_CPLUS = 4'd1,  OP_MINUS = 4'd2;
  localparam logic [3:0] OP_RMINUS = 4'd3, OP_CMINUS = 4'd4, OP_RCMINUS = 4'd5;
  localparam logic [3:0] OP_MULT  = 4'd6,  OP_AND   = 4'd7,  OP_XOR   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9,  OP_NOT   = 4'd10, OP_CLEAR = 4'd11;
  localparam logic [3:0] OP_RRX   = 4'd12, OP_MOVE  = 4'd13;

  // Remaining-cycle count loaded for MUL; the final EXEC cycle has count 0.
  localparam logic [1:0] MUL_LAST = 2'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_SKIP = 2'd2} state_t;

  // Flag-update class: which NZVC bits the ALU result may overwrite.
  localparam logic [1:0] FC_ARITH = 2'd0, FC_LOGIC = 2'd1, FC_MUL = 2'd2;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  cls_q, cls_d;
  logic        s_q, s_d, test_q, test_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        op_swap_q, op_swap_d;
  logic [3:0]  rn_q, rn_d, rd_q, rd_d, rm_q, rm_d, rs_q, rs_d;
  logic        op2_imm_q, op2_imm_d;
  logic [11:0] op2_field_q, op2_field_d;
  logic [3:0]  flags_q, flags_d;
  logic        rd_we_q, rd_we_d, done_q, done_d, illegal_q, illegal_d;
  logic        ready_q, ready_d;

  logic        dec_mul_s, dec_legal_s, dec_test_s, dec_swap_s;
  logic [3:0]  dec_op_s;
  logic [1:0]  dec_cls_s;
  logic        final_s;

  // Standard ARM condition evaluation; NV never passes.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, r;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = cy;
      4'h3:    r = ~cy;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = cy & ~z;
      4'h9:    r = ~cy | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Decode the offered instruction word into ALU op, flag class and legality.
  always_comb begin
    dec_mul_s   = (instr[27:22] == 6'b000000) && (instr[7:4] == 4'b1001);
    dec_legal_s = dec_mul_s || (instr[27:26] == 2'b00);
    dec_op_s    = OP_MOVE;
    dec_cls_s   = FC_LOGIC;
    dec_test_s  = 1'b0;
    dec_swap_s  = 1'b0;
    if (dec_mul_s) begin
      dec_op_s  = OP_MULT;
      dec_cls_s = FC_MUL;
    end else if (dec_legal_s) begin
      case (instr[24:21])
        4'h0:    dec_op_s = OP_AND;
        4'h1:    dec_op_s = OP_XOR;
        4'h2:    begin dec_op_s = OP_MINUS;   dec_cls_s = FC_ARITH; end
        4'h3:    begin dec_op_s = OP_RMINUS;  dec_cls_s = FC_ARITH; end
        4'h4:    begin dec_op_s = OP_PLUS;    dec_cls_s = FC_ARITH; end
        4'h5:    begin dec_op_s = OP_CPLUS;   dec_cls_s = FC_ARITH; end
        4'h6:    begin dec_op_s = OP_CMINUS;  dec_cls_s = FC_ARITH; end
        4'h7:    begin dec_op_s = OP_RCMINUS; dec_cls_s = FC_ARITH; end
        4'h8:    begin dec_op_s = OP_AND;     dec_test_s = 1'b1; end
        4'h9:    begin dec_op_s = OP_XOR;     dec_test_s = 1'b1; end
        4'hA:    begin dec_op_s = OP_MINUS;   dec_cls_s = FC_ARITH; dec_test_s = 1'b1; end
        4'hB:    begin dec_op_s = OP_PLUS;    dec_cls_s = FC_ARITH; dec_test_s = 1'b1; end
        4'hC:    dec_op_s = OP_OR;
        4'hD:    begin
          if (!instr[25] && (instr[11:4] == 8'b0000_0110)) begin
            dec_op_s = OP_RRX;
          end else begin
            dec_op_s = OP_MOVE;
          end
        end
        4'hE:    dec_op_s = OP_CLEAR;
        default: begin dec_op_s = OP_NOT; dec_swap_s = 1'b1; end
      endcase
    end else begin
      dec_op_s = OP_MOVE;
    end
  end

  // Next state, latched fields, flag register and registered strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cls_d       = cls_q;
    s_d         = s_q;
    test_d      = test_q;
    alu_op_d    = alu_op_q;
    op_swap_d   = op_swap_q;
    rn_d        = rn_q;
    rd_d        = rd_q;
    rm_d        = rm_q;
    rs_d        = rs_q;
    op2_imm_d   = op2_imm_q;
    op2_field_d = op2_field_q;
    flags_d     = flags_q;
    illegal_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          alu_op_d    = dec_op_s;
          op_swap_d   = dec_swap_s;
          cls_d       = dec_cls_s;
          test_d      = dec_test_s;
          s_d         = instr[20];
          rn_d        = dec_mul_s ? instr[15:12] : instr[19:16];
          rd_d        = dec_mul_s ? instr[19:16] : instr[15:12];
          rm_d        = instr[3:0];
          rs_d        = instr[11:8];
          op2_imm_d   = instr[25];
          op2_field_d = instr[11:0];
          illegal_d   = ~dec_legal_s;
          if (dec_legal_s && cond_pass(instr[31:28], flags_q)) begin
            state_d = S_EXEC;
            cnt_d   = dec_mul_s ? MUL_LAST : 2'd0;
          end else begin
            state_d = S_SKIP;
            cnt_d   = 2'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q == 2'd0) begin
          state_d = S_IDLE;
          if (s_q || test_q) begin
            case (cls_q)
              FC_ARITH: flags_d = alu_nzvc;
              FC_MUL:   flags_d = {alu_nzvc[3:2], flags_q[1:0]};
              default:  flags_d = {alu_nzvc[3:2], flags_q[1], alu_nzvc[0]};
            endcase
          end else begin
            flags_d = flags_q;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_SKIP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A direct flag write overrides any ALU capture in the same cycle.
    if (flags_load) begin
      flags_d = flags_in;
    end else begin
      flags_d = flags_d;
    end
    final_s = (state_d == S_EXEC) && (cnt_d == 2'd0);
    ready_d = (state_d == S_IDLE);
    rd_we_d = final_s && !test_d;
    done_d  = final_s || (state_d == S_SKIP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      cls_q       <= FC_LOGIC;
      s_q         <= 1'b0;
      test_q      <= 1'b0;
      alu_op_q    <= OP_MOVE;
      op_swap_q   <= 1'b0;
      rn_q        <= 4'd0;
      rd_q        <= 4'd0;
      rm_q        <= 4'd0;
      rs_q        <= 4'd0;
      op2_imm_q   <= 1'b0;
      op2_field_q <= 12'd0;
      flags_q     <= 4'd0;
      rd_we_q     <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cls_q       <= cls_d;
      s_q         <= s_d;
      test_q      <= test_d;
      alu_op_q    <= alu_op_d;
      op_swap_q   <= op_swap_d;
      rn_q        <= rn_d;
      rd_q        <= rd_d;
      rm_q        <= rm_d;
      rs_q        <= rs_d;
      op2_imm_q   <= op2_imm_d;
      op2_field_q <= op2_field_d;
      flags_q     <= flags_d;
      rd_we_q     <= rd_we_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      ready_q     <= ready_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_op      = alu_op_q;
  assign alu_carry   = flags_q[0];
  assign op_swap     = op_swap_q;
  assign rn_addr     = rn_q;
  assign rd_addr     = rd_q;
  assign rm_addr     = rm_q;
  assign rs_addr     = rs_q;
  assign op2_imm     = op2_imm_q;
  assign op2_field   = op2_field_q;
  assign rd_we       = rd_we_q;
  assign flags       = flags_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed steps plus randomized
// instructions compared against an instruction-level reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [3:0]  alu_op;
  logic        alu_carry;
  logic        op_swap;
  logic [3:0]  alu_nzvc;
  logic [3:0]  rn_addr, rd_addr, rm_addr, rs_addr;
  logic        op2_imm;
  logic [11:0] op2_field;
  logic        rd_we;
  logic        flags_load;
  logic [3:0]  flags_in;
  logic [3:0]  flags;
  logic        done;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags;  // reference NZVC

  alu_issue_ctrl #(.MUL_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_carry(alu_carry),
    .op_swap(op_swap), .alu_nzvc(alu_nzvc), .rn_addr(rn_addr),
    .rd_addr(rd_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
    .op2_imm(op2_imm), .op2_field(op2_field), .rd_we(rd_we),
    .flags_load(flags_load), .flags_in(flags_in), .flags(flags),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ARM condition truth table, by name.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v, cy;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'd0:  return z;                 // EQ
      4'd1:  return !z;                // NE
      4'd2:  return cy;                // CS
      4'd3:  return !cy;               // CC
      4'd4:  return n;                 // MI
      4'd5:  return !n;                // PL
      4'd6:  return v;                 // VS
      4'd7:  return !v;                // VC
      4'd8:  return cy && !z;          // HI
      4'd9:  return !cy || z;          // LS
      4'd10: return n == v;            // GE
      4'd11: return n != v;            // LT
      4'd12: return !z && (n == v);    // GT
      4'd13: return z || (n != v);     // LE
      4'd14: return 1'b1;              // AL
      default: return 1'b0;            // NV
    endcase
  endfunction

  task automatic load_flags(input logic [3:0] v);
    flags_load = 1'b1; flags_in = v;
    @(posedge clk); @(negedge clk);
    flags_load = 1'b0;
    mflags = v;
    chk("flags_load", flags, mflags);
  endtask

  // Issue one instruction and follow it to retire, checking every cycle.
  task automatic issue(input logic [31:0] ins, input logic [3:0] nz,
                       input bit lda, input logic [3:0] ldav,
                       input bit ldf, input logic [3:0] ldfv);
    logic [3:0] dp_map [16];
    bit mul, legal, test, arith, pass, last;
    logic [3:0] eop, erd;
    int ncyc, guard;
    dp_map = '{4'd7, 4'd8, 4'd2, 4'd3, 4'd0, 4'd1, 4'd4, 4'd5,
               4'd7, 4'd8, 4'd2, 4'd0, 4'd9, 4'd13, 4'd11, 4'd10};
    mul   = (ins[27:22] == 6'd0) && (ins[7:4] == 4'd9);
    legal = mul || (ins[27:26] == 2'd0);
    test  = !mul && (ins[24:21] >= 4'd8) && (ins[24:21] <= 4'd11);
    arith = !mul && (ins[24:21] inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11});
    if (mul) eop = 4'd6;
    else if (ins[24:21] == 4'd13 && !ins[25] && ins[11:4] == 8'h06) eop = 4'd12;
    else eop = dp_map[ins[24:21]];
    erd  = mul ? ins[19:16] : ins[15:12];
    ncyc = mul ? 2 : 1;
    guard = 0;
    while (!instr_ready && guard < 20) begin @(negedge clk); guard++; end
    chk("ready_idle", instr_ready, 1'b1);
    instr = ins; instr_valid = 1'b1; alu_nzvc = nz;
    flags_load = lda; flags_in = ldav;
    pass = legal && cond_ok(ins[31:28], mflags);
    if (lda) mflags = ldav;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0; flags_load = 1'b0;
    if (pass) begin
      for (int k = 0; k < ncyc; k++) begin
        last = (k == ncyc - 1);
        chk("exec_op", alu_op, eop);
        chk("exec_ready", instr_ready, 1'b0);
        chk("exec_rd", rd_addr, erd);
        chk("exec_rm", rm_addr, ins[3:0]);
        chk("exec_rs", rs_addr, ins[11:8]);
        if (!mul) chk("exec_rn", rn_addr, ins[19:16]);
        chk("exec_op2", {op2_imm, op2_field}, {ins[25], ins[11:0]});
        chk("exec_we", rd_we, last && !test);
        chk("exec_done", done, last);
        chk("exec_ill", illegal, 1'b0);
        chk("exec_cin", alu_carry, mflags[0]);
        chk("exec_swap", op_swap, eop == 4'd10);
        if (last && ldf) begin flags_load = 1'b1; flags_in = ldfv; end
        @(posedge clk); @(negedge clk);
        flags_load = 1'b0;
      end
      if (ins[20] || test) begin
        if (arith) mflags = nz;
        else if (mul) mflags = {nz[3:2], mflags[1:0]};
        else mflags = {nz[3:2], mflags[1], nz[0]};
      end
      if (ldf) mflags = ldfv;
    end else begin
      chk("skip_done", done, 1'b1);
      chk("skip_ill", illegal, !legal);
      chk("skip_we", rd_we, 1'b0);
      chk("skip_ready", instr_ready, 1'b0);
      @(posedge clk); @(negedge clk);
    end
    chk("retire_flags", flags, mflags);
    chk("retire_done_clr", done, 1'b0);
    chk("retire_we_clr", rd_we, 1'b0);
  endtask

  initial begin
    logic [31:0] ins;
    reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; alu_nzvc = 4'd0;
    flags_load = 1'b0; flags_in = 4'd0; mflags = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_flags", flags, 4'd0);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_op", alu_op, 4'd13);
    chk("rst_we", rd_we, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ill", illegal, 1'b0);
    chk("rst_rd", {rn_addr, rd_addr, rm_addr, rs_addr}, 16'd0);

    issue(32'hE0912003, 4'b0110, 1'b0, 4'd0, 1'b0, 4'd0);   // ADDS r2,r1,r3
    load_flags(4'b0000);
    issue(32'h01A00001, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0);   // MOVEQ skipped
    load_flags(4'b0100);
    issue(32'h01A00001, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0);   // MOVEQ executes
    issue(32'hE1510003, 4'b1001, 1'b0, 4'd0, 1'b0, 4'd0);   // CMP r1,r3
    load_flags(4'b0001);
    issue(32'hE1A00061, 4'b1110, 1'b0, 4'd0, 1'b0, 4'd0);   // MOV RRX, S=0
    issue(32'hE0000291, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0);   // MUL
    issue(32'hE0100291, 4'b1100, 1'b0, 4'd0, 1'b0, 4'd0);   // MULS keeps C,V
    issue(32'hEC000000, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0);   // illegal
    issue(32'hE0912003, 4'b0110, 1'b0, 4'd0, 1'b1, 4'b1010); // load wins
    load_flags(4'b0100);
    issue(32'h01A00001, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0); // accept uses old Z
    issue(32'hF0912003, 4'b0110, 1'b0, 4'd0, 1'b0, 4'd0);   // NV never

    // Reset during the first EXEC cycle of MUL aborts it.
    load_flags(4'b1011);
    instr = 32'hE0000291; instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    chk("mulrst_op", alu_op, 4'd6);
    chk("mulrst_ready", instr_ready, 1'b0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; mflags = 4'd0;
    chk("mulrst_we", rd_we, 1'b0);
    chk("mulrst_done", done, 1'b0);
    chk("mulrst_flags", flags, 4'd0);
    chk("mulrst_ready", instr_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("mulrst_we2", rd_we, 1'b0);
    chk("mulrst_flags2", flags, 4'd0);

    for (int i = 0; i < 60; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 3))
        0: ins[27:26] = 2'b00;
        1: begin ins[27:22] = 6'd0; ins[7:4] = 4'b1001; end
        2: begin ins[27:25] = 3'b000; ins[24:21] = 4'd13; ins[11:4] = 8'h06; end
        default: ins = ins;
      endcase
      if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
      issue(ins, 4'($urandom), $urandom_range(0, 7) == 0, 4'($urandom),
            $urandom_range(0, 5) == 0, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
